// File: rtl/ctr_run_ctrl_pkg.sv
// ctr_run_ctrl_pkg
//   Shared types and constants for the counter run sequencer.
//   state_e     : sequencer states (IDLE, LOAD, RUN, DONE)
//   UP / DN     : encodings of the counter up_dn input
//   LOAD_ACTIVE : asserted level of the counter's active-low load input
package ctr_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic UP          = 1'b1;
  localparam logic DN          = 1'b0;
  localparam logic LOAD_ACTIVE = 1'b0;

endpackage

// File: rtl/ctr_run_ctrl_if.sv
// ctr_run_ctrl_if
//   Bundles the job-command side and the counter side of the sequencer.
//   Job side    : start, start_data, start_up_dn, reload_data, passes,
//                 bounce, abort (in to sequencer); busy, done, aborted,
//                 pass_cnt (out of sequencer).
//   Counter side: tercnt (in to sequencer); ctr_data, ctr_up_dn,
//                 ctr_load_n, ctr_cen (out of sequencer).
//   master : the environment (software model + counter)
//   slave  : the sequencer itself
interface ctr_run_ctrl_if #(
  parameter int width  = 12,
  parameter int pass_w = 8
) ();

  logic              start;
  logic [width-1:0]  start_data;
  logic              start_up_dn;
  logic [width-1:0]  reload_data;
  logic [pass_w-1:0] passes;
  logic              bounce;
  logic              abort;
  logic              tercnt;
  logic [width-1:0]  ctr_data;
  logic              ctr_up_dn;
  logic              ctr_load_n;
  logic              ctr_cen;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [pass_w-1:0] pass_cnt;

  modport master (
    output start, start_data, start_up_dn, reload_data, passes, bounce,
           abort, tercnt,
    input  ctr_data, ctr_up_dn, ctr_load_n, ctr_cen, busy, done, aborted,
           pass_cnt
  );

  modport slave (
    input  start, start_data, start_up_dn, reload_data, passes, bounce,
           abort, tercnt,
    output ctr_data, ctr_up_dn, ctr_load_n, ctr_cen, busy, done, aborted,
           pass_cnt
  );

endinterface

// File: rtl/ctr_run_ctrl.sv
// ctr_run_ctrl
//   Sequencer in front of an up/down counter with static count-to logic.
//   Preloads a start value, counts a programmed number of terminal-count
//   passes (reloading and optionally reversing direction on each non-final
//   pass), then pulses done. A running job can be aborted.
//   Ports:
//     i_clk   : clock, all state changes on the rising edge
//     i_reset : synchronous active-high reset
//     io_bus  : ctr_run_ctrl_if.slave, job command/status and counter drive
//   ctr_load_n / ctr_cen are combinational from state, tercnt, pass_cnt and
//   abort; every other output is registered.
module ctr_run_ctrl
  import ctr_run_ctrl_pkg::*;
#(
  parameter int width  = 12,
  parameter int pass_w = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  ctr_run_ctrl_if.slave   io_bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [width-1:0]  r_reload_data;
  logic [pass_w-1:0] r_passes;
  logic              r_bounce;
  logic [width-1:0]  r_ctr_data;
  logic              r_ctr_up_dn;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic [pass_w-1:0] r_pass_cnt;

  logic [pass_w:0]   w_pass_inc;
  logic              w_final;
  logic              w_load_n;
  logic              w_cen;

  // Pass bookkeeping: one extra bit so the increment can never wrap.
  always_comb begin
    w_pass_inc = {1'b0, r_pass_cnt} + {{pass_w{1'b0}}, 1'b1};
    w_final    = (w_pass_inc >= {1'b0, r_passes});
  end

  // Next-state and counter-control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_n    = ~LOAD_ACTIVE;
    w_cen       = 1'b0;
    if (i_reset) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            w_state_nxt = (io_bus.passes != {pass_w{1'b0}}) ? LOAD : DONE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        LOAD: begin
          if (io_bus.abort) begin
            w_state_nxt = IDLE;
          end else begin
            w_load_n    = LOAD_ACTIVE;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (io_bus.abort) begin
            w_state_nxt = IDLE;
          end else if (io_bus.tercnt) begin
            if (w_final) begin
              // Final pass: freeze the counter on its terminal value.
              w_state_nxt = DONE;
            end else begin
              // Non-final pass: load overrides count inside the counter.
              w_load_n = LOAD_ACTIVE;
              w_cen    = 1'b1;
            end
          end else begin
            w_cen = 1'b1;
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, job latches and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_reload_data <= {width{1'b0}};
      r_passes      <= {pass_w{1'b0}};
      r_bounce      <= 1'b0;
      r_ctr_data    <= {width{1'b0}};
      r_ctr_up_dn   <= UP;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
      r_pass_cnt    <= {pass_w{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == DONE);
      r_aborted <= io_bus.abort && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (io_bus.start) begin
            r_pass_cnt <= {pass_w{1'b0}};
            if (io_bus.passes != {pass_w{1'b0}}) begin
              r_ctr_data    <= io_bus.start_data;
              r_reload_data <= io_bus.reload_data;
              r_passes      <= io_bus.passes;
              r_bounce      <= io_bus.bounce;
              r_ctr_up_dn   <= io_bus.start_up_dn;
            end
          end
        end
        LOAD: begin
          // From RUN onward the data bus only ever carries the reload value,
          // so it can be staged here and stay registered.
          if (!io_bus.abort) begin
            r_ctr_data <= r_reload_data;
          end
        end
        RUN: begin
          if (!io_bus.abort && io_bus.tercnt) begin
            r_pass_cnt <= w_pass_inc[pass_w-1:0];
            if (!w_final && r_bounce) begin
              r_ctr_up_dn <= ~r_ctr_up_dn;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.ctr_data   = r_ctr_data;
  assign io_bus.ctr_up_dn  = r_ctr_up_dn;
  assign io_bus.ctr_load_n = w_load_n;
  assign io_bus.ctr_cen    = w_cen;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.aborted    = r_aborted;
  assign io_bus.pass_cnt   = r_pass_cnt;

endmodule

// File: tb/tb_ctr_run_ctrl.sv
// tb_ctr_run_ctrl
//   Directed bench for ctr_run_ctrl driving a behavioural 12-bit up/down
//   counter with count_to = 12. Each "cycle" starts 1 time unit after a
//   rising edge; inputs are applied, then outputs are checked 1 unit later.
module tb_ctr_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [11:0] r_count;

  always #5 clk = ~clk;

  ctr_run_ctrl_if #(.width(12), .pass_w(8)) bus ();

  ctr_run_ctrl #(.width(12), .pass_w(8)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  // Counter model: load (active low) beats count enable; count_to = 12.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 12'd0;
    end else if (!bus.ctr_load_n) begin
      r_count <= bus.ctr_data;
    end else if (bus.ctr_cen) begin
      r_count <= bus.ctr_up_dn ? r_count + 12'd1 : r_count - 12'd1;
    end
  end

  assign bus.tercnt = (r_count == 12'd12);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue start in the current cycle k; returns settled in cycle k+1.
  task automatic start_job(input logic [11:0] sd, input logic up,
                           input logic [11:0] rd, input logic [7:0] np,
                           input logic bnc);
    bus.start_data  = sd;
    bus.start_up_dn = up;
    bus.reload_data = rd;
    bus.passes      = np;
    bus.bounce      = bnc;
    bus.start       = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.start_data  = 12'd0;
    bus.start_up_dn = 1'b1;
    bus.reload_data = 12'd0;
    bus.passes      = 8'd0;
    bus.bounce      = 1'b0;
    bus.abort       = 1'b0;
    cyc(2);
    chk("rst_load_n",   32'(bus.ctr_load_n), 32'd1);
    chk("rst_cen",      32'(bus.ctr_cen),    32'd0);
    chk("rst_up_dn",    32'(bus.ctr_up_dn),  32'd1);
    chk("rst_data",     32'(bus.ctr_data),   32'd0);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_done",     32'(bus.done),       32'd0);
    chk("rst_aborted",  32'(bus.aborted),    32'd0);
    chk("rst_pass_cnt", 32'(bus.pass_cnt),   32'd0);
    reset = 1'b0;
    cyc(1);

    // 1: 0 up, 2 passes, reload 0
    start_job(12'd0, 1'b1, 12'd0, 8'd2, 1'b0);
    chk("t1_load_n_k1", 32'(bus.ctr_load_n), 32'd0);
    chk("t1_data_k1",   32'(bus.ctr_data),   32'd0);
    chk("t1_busy_k1",   32'(bus.busy),       32'd1);
    cyc(1);
    chk("t1_cen_k2",    32'(bus.ctr_cen),    32'd1);
    chk("t1_load_n_k2", 32'(bus.ctr_load_n), 32'd1);
    cyc(12);
    chk("t1_tercnt_k14", 32'(bus.tercnt),     32'd1);
    chk("t1_reload_k14", 32'(bus.ctr_load_n), 32'd0);
    chk("t1_cen_k14",    32'(bus.ctr_cen),    32'd1);
    cyc(1);
    chk("t1_count_k15",  32'(r_count),        32'd0);
    chk("t1_pass_k15",   32'(bus.pass_cnt),   32'd1);
    cyc(12);
    chk("t1_tercnt_k27", 32'(bus.tercnt),     32'd1);
    chk("t1_cen_k27",    32'(bus.ctr_cen),    32'd0);
    chk("t1_load_n_k27", 32'(bus.ctr_load_n), 32'd1);
    chk("t1_done_k27",   32'(bus.done),       32'd0);
    cyc(1);
    chk("t1_done_k28",   32'(bus.done),       32'd1);
    chk("t1_pass_k28",   32'(bus.pass_cnt),   32'd2);
    chk("t1_count_k28",  32'(r_count),        32'd12);
    cyc(1);
    chk("t1_done_k29",   32'(bus.done),       32'd0);
    chk("t1_busy_k29",   32'(bus.busy),       32'd0);
    chk("t1_count_k29",  32'(r_count),        32'd12);

    // 2: 20 down, 1 pass
    start_job(12'd20, 1'b0, 12'd5, 8'd1, 1'b0);
    chk("t2_data_k1",   32'(bus.ctr_data),  32'd20);
    chk("t2_up_dn_k1",  32'(bus.ctr_up_dn), 32'd0);
    cyc(1);
    chk("t2_data_k2",   32'(bus.ctr_data),  32'd5);
    cyc(7);
    chk("t2_count_k9",  32'(r_count),       32'd13);
    chk("t2_cen_k9",    32'(bus.ctr_cen),   32'd1);
    cyc(1);
    chk("t2_tercnt_k10", 32'(bus.tercnt),   32'd1);
    chk("t2_cen_k10",   32'(bus.ctr_cen),   32'd0);
    cyc(1);
    chk("t2_done_k11",  32'(bus.done),      32'd1);
    chk("t2_cen_k11",   32'(bus.ctr_cen),   32'd0);
    cyc(1);
    chk("t2_count_k12", 32'(r_count),       32'd12);
    chk("t2_pass_k12",  32'(bus.pass_cnt),  32'd1);

    // 3: bounce, reload onto count_to, 3 passes on consecutive cycles
    start_job(12'd0, 1'b1, 12'd12, 8'd3, 1'b1);
    cyc(13);
    chk("t3_tercnt_k14", 32'(bus.tercnt),    32'd1);
    chk("t3_up_dn_k14",  32'(bus.ctr_up_dn), 32'd1);
    chk("t3_pass_k14",   32'(bus.pass_cnt),  32'd0);
    cyc(1);
    chk("t3_up_dn_k15",  32'(bus.ctr_up_dn), 32'd0);
    chk("t3_pass_k15",   32'(bus.pass_cnt),  32'd1);
    chk("t3_load_n_k15", 32'(bus.ctr_load_n), 32'd0);
    cyc(1);
    chk("t3_up_dn_k16",  32'(bus.ctr_up_dn), 32'd1);
    chk("t3_pass_k16",   32'(bus.pass_cnt),  32'd2);
    chk("t3_cen_k16",    32'(bus.ctr_cen),   32'd0);
    cyc(1);
    chk("t3_done_k17",   32'(bus.done),      32'd1);
    chk("t3_pass_k17",   32'(bus.pass_cnt),  32'd3);
    cyc(1);

    // 4: passes = 0
    start_job(12'd7, 1'b1, 12'd7, 8'd0, 1'b0);
    chk("t4_done_k1",   32'(bus.done),       32'd1);
    chk("t4_busy_k1",   32'(bus.busy),       32'd1);
    chk("t4_pass_k1",   32'(bus.pass_cnt),   32'd0);
    chk("t4_load_n_k1", 32'(bus.ctr_load_n), 32'd1);
    chk("t4_cen_k1",    32'(bus.ctr_cen),    32'd0);
    cyc(1);
    chk("t4_done_k2",   32'(bus.done),       32'd0);
    chk("t4_load_n_k2", 32'(bus.ctr_load_n), 32'd1);
    chk("t4_count_k2",  32'(r_count),        32'd12);

    // 5: abort in 5th RUN cycle; a mid-run start is ignored
    start_job(12'd0, 1'b1, 12'd0, 8'd2, 1'b0);
    cyc(3);
    bus.start_data = 12'd100;
    bus.start      = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    #1;
    chk("t5_count_k5",  32'(r_count),        32'd3);
    chk("t5_busy_k5",   32'(bus.busy),       32'd1);
    cyc(1);
    bus.abort = 1'b1;
    #1;
    chk("t5_cen_abort",    32'(bus.ctr_cen),    32'd0);
    chk("t5_load_n_abort", 32'(bus.ctr_load_n), 32'd1);
    cyc(1);
    bus.abort = 1'b0;
    #1;
    chk("t5_aborted_k7", 32'(bus.aborted),  32'd1);
    chk("t5_done_k7",    32'(bus.done),     32'd0);
    chk("t5_busy_k7",    32'(bus.busy),     32'd0);
    chk("t5_count_k7",   32'(r_count),      32'd4);
    chk("t5_pass_k7",    32'(bus.pass_cnt), 32'd0);
    cyc(1);
    chk("t5_aborted_k8", 32'(bus.aborted),  32'd0);
    chk("t5_count_k8",   32'(r_count),      32'd4);

    // 6: reset in RUN with start held through reset
    start_job(12'd30, 1'b0, 12'd30, 8'd2, 1'b0);
    cyc(4);
    reset     = 1'b1;
    bus.start = 1'b1;
    cyc(1);
    chk("t6_busy_r",     32'(bus.busy),       32'd0);
    chk("t6_data_r",     32'(bus.ctr_data),   32'd0);
    chk("t6_up_dn_r",    32'(bus.ctr_up_dn),  32'd1);
    chk("t6_load_n_r",   32'(bus.ctr_load_n), 32'd1);
    chk("t6_cen_r",      32'(bus.ctr_cen),    32'd0);
    chk("t6_pass_r",     32'(bus.pass_cnt),   32'd0);
    cyc(1);
    chk("t6_load_n_r2",  32'(bus.ctr_load_n), 32'd1);
    chk("t6_busy_r2",    32'(bus.busy),       32'd0);
    reset = 1'b0;
    cyc(1);
    bus.start = 1'b0;
    #1;
    chk("t6_load_n_rel", 32'(bus.ctr_load_n), 32'd0);
    chk("t6_busy_rel",   32'(bus.busy),       32'd1);
    chk("t6_data_rel",   32'(bus.ctr_data),   32'd30);
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    #1;
    chk("t6_aborted",    32'(bus.aborted),    32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ctr_run_ctrl.md
Name: ctr_run_ctrl

Overview:
- Sequencer directly upstream of the team's up/down counter with static count-to logic.
- Drives the counter's data, up_dn, load (active low) and cen inputs, and consumes its tercnt output.
- Runs a software-commanded job: preload a start value, count a programmed number of terminal-count passes, reload on each pass (optionally reversing direction), then pulse done.
- Replaces the ad-hoc "tercnt through an inverter into load" hookup with a controlled, abortable run.

Parameters:
- width, 12, counter data width; must equal the attached counter's width.
- pass_w, 8, width of the pass-count fields.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- start_data  in  width  initial counter value for the job.
- start_up_dn  in  1  initial direction; 1 = up, 0 = down.
- reload_data  in  width  value loaded into the counter at each non-final terminal count.
- passes  in  pass_w  number of terminal-count events that end the job.
- bounce  in  1  1 = invert direction at every reload.
- abort  in  1  cancels a running job.
- tercnt  in  1  terminal-count flag from the counter (combinational from its count register).
- ctr_data  out  width  to counter data.
- ctr_up_dn  out  1  to counter up_dn.
- ctr_load_n  out  1  to counter load; active low.
- ctr_cen  out  1  to counter cen.
- busy  out  1  high in LOAD, RUN and DONE.
- done  out  1  one-cycle pulse when a job completes.
- aborted  out  1  one-cycle pulse when a job is aborted.
- pass_cnt  out  pass_w  terminal-count events counted in the current or last job.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state IDLE; ctr_load_n=1, ctr_cen=0, ctr_up_dn=1, ctr_data=0.
  - busy=0, done=0, aborted=0, pass_cnt=0.
  - Any state is abandoned immediately.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - ctr_load_n=1, ctr_cen=0.
  - On start=1 with passes!=0: latch start_data, reload_data, passes, bounce and start_up_dn into ctr_up_dn; clear pass_cnt; go to LOAD.
  - On start=1 with passes==0: clear pass_cnt and go directly to DONE with no counter activity.
- LOAD (1 cycle): ctr_load_n=0, ctr_data=latched start_data, ctr_cen=0; go to RUN.
- RUN, tercnt=0: ctr_cen=1, ctr_load_n=1.
- RUN, tercnt=1, non-final (pass_cnt+1 < latched passes):
  - ctr_load_n=0, ctr_data=latched reload_data, ctr_cen=1 (load wins in the counter).
  - pass_cnt increments.
  - If bounce, ctr_up_dn toggles at this edge and takes effect from the next cycle.
- RUN, tercnt=1, final (pass_cnt+1 == latched passes):
  - ctr_cen=0, ctr_load_n=1, so the counter holds its terminal value.
  - pass_cnt increments; go to DONE.
- DONE (1 cycle): done=1, ctr_cen=0, ctr_load_n=1; go to IDLE.
- ctr_load_n and ctr_cen are combinational from state, tercnt and pass_cnt. All other outputs are registered.
- tercnt is honoured in every RUN cycle, including the first. If start_data equals the counter's count_to, that counts as a pass immediately.
- If reload_data equals count_to, each subsequent RUN cycle counts another pass.
- abort=1 in LOAD, RUN or DONE:
  - Next state IDLE; aborted=1 for one cycle; done not pulsed; pass_cnt retained.
  - ctr_cen=0 and ctr_load_n=1 in the abort cycle.
- Priority: reset > abort > normal transitions. abort in IDLE is ignored.
- start while busy is ignored; no queueing.
- pass_cnt wraps are impossible, since the job ends at passes ≤ 2^pass_w−1.
- Latency: start sampled in cycle k → ctr_load_n=0 in cycle k+1 → RUN from k+2.

Decomposition:
- Shared package:
  - state enum (IDLE, LOAD, RUN, DONE);
  - constants UP=1'b1, DN=1'b0 and LOAD_ACTIVE=1'b0.
- No sub-module; single FSM plus pass counter.
- The bench instantiates the existing counter (width=12, count_to=12) as the DUT's load.

Test Plan:
1. start_data=0, up, passes=2, reload_data=0, bounce=0, started in cycle k → ctr_load_n=0 at k+1; tercnt at k+14 with reload; count 12 again at k+27; done=1 at k+28; count holds 12; pass_cnt=2.
2. start_data=20, down, passes=1 → counts 20→12 in 8 RUN cycles; done 1 cycle later; final count 12; ctr_cen=0 from the tercnt cycle onward.
3. bounce=1, start_data=0, up, reload_data=12, passes=3 → reload to 12 re-hits tercnt the next cycle. Passes counted on consecutive cycles; ctr_up_dn toggles 1→0→1; done after 3 passes.
4. passes=0 with start → done pulse 1 cycle later; ctr_load_n and ctr_cen never asserted; pass_cnt=0.
5. abort in the 5th RUN cycle → aborted=1 next cycle; no done; ctr_cen=0; counter holds its value. A second start mid-run is ignored.
6. reset=1 asserted in RUN → next cycle all outputs at reset values. A start held during reset is not accepted until the first cycle with reset=0.
